// File: rtl/maxpool2d_param_mode.sv
// Parametrised 2-D max/average pooling engine.
// The input feature map is loaded through a write port into an internal
// buffer. A start pulse walks every output position (channel-major order),
// fetches one window element per cycle, then writes one pooled result. The
// results are read back through a registered read port.
module maxpool2d_param_mode #(
    parameter int DATA_W   = 4,
    parameter int IN_H     = 8,
    parameter int IN_W     = 8,
    parameter int CHANNELS = 128,
    parameter int K        = 2,
    parameter int STRIDE   = 2,
    parameter int ADDR_W   = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     mode,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]        read_addr,
    output logic signed [DATA_W-1:0] read_data,
    output logic                     busy,
    output logic                     done
);

    // Output geometry: trailing rows/columns without a full window are dropped.
    localparam int OH     = (IN_H - K) / STRIDE + 1;
    localparam int OW     = (IN_W - K) / STRIDE + 1;
    localparam int OUT_N  = CHANNELS * OH * OW;
    localparam int IN_N   = CHANNELS * IN_H * IN_W;
    localparam int IA_W   = $clog2(IN_N);
    localparam int OA_W   = $clog2(OUT_N);
    localparam int KW     = $clog2(K);
    // K is 2 or 4, so K*K is a power of two and the average is a pure shift.
    localparam int LOG2KK = 2 * KW;
    localparam int SUM_W  = DATA_W + LOG2KK;
    localparam int CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int YW     = (OH > 1) ? $clog2(OH) : 1;
    localparam int XW     = (OW > 1) ? $clog2(OW) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FETCH  = 2'd1;
    localparam logic [1:0] WRITE  = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    localparam logic [ADDR_W-1:0] IN_N_A  = ADDR_W'(IN_N);
    localparam logic [ADDR_W-1:0] OUT_N_A = ADDR_W'(OUT_N);
    localparam logic [KW-1:0]     K_LAST  = KW'(K - 1);
    localparam logic [KW-1:0]     K_ZERO  = KW'(0);
    localparam logic [KW-1:0]     K_ONE   = KW'(1);
    localparam logic [CW-1:0]     C_LAST  = CW'(CHANNELS - 1);
    localparam logic [CW-1:0]     C_ZERO  = CW'(0);
    localparam logic [CW-1:0]     C_ONE   = CW'(1);
    localparam logic [YW-1:0]     Y_LAST  = YW'(OH - 1);
    localparam logic [YW-1:0]     Y_ZERO  = YW'(0);
    localparam logic [YW-1:0]     Y_ONE   = YW'(1);
    localparam logic [XW-1:0]     X_LAST  = XW'(OW - 1);
    localparam logic [XW-1:0]     X_ZERO  = XW'(0);
    localparam logic [XW-1:0]     X_ONE   = XW'(1);

    logic signed [DATA_W-1:0] in_buf  [0:IN_N-1];
    logic signed [DATA_W-1:0] out_buf [0:OUT_N-1];

    logic [1:0]              state_r;
    logic                    mode_r;
    logic [CW-1:0]           c_r;
    logic [YW-1:0]           oy_r;
    logic [XW-1:0]           ox_r;
    logic [KW-1:0]           ky_r;
    logic [KW-1:0]           kx_r;
    logic signed [SUM_W-1:0] acc_r;

    logic [IA_W-1:0]          iy_s;
    logic [IA_W-1:0]          ix_s;
    logic [IA_W-1:0]          in_idx_s;
    logic [OA_W-1:0]          out_idx_s;
    logic signed [DATA_W-1:0] elem_s;
    logic signed [SUM_W-1:0]  elem_ext_s;
    logic signed [DATA_W-1:0] result_s;
    logic                     win_first_s;
    logic                     win_last_s;
    logic                     out_last_s;

    // Address generation for the current window element and output slot.
    always_comb begin
        iy_s        = IA_W'(oy_r) * IA_W'(STRIDE) + IA_W'(ky_r);
        ix_s        = IA_W'(ox_r) * IA_W'(STRIDE) + IA_W'(kx_r);
        in_idx_s    = (IA_W'(c_r) * IA_W'(IN_H) + iy_s) * IA_W'(IN_W) + ix_s;
        out_idx_s   = (OA_W'(c_r) * OA_W'(OH) + OA_W'(oy_r)) * OA_W'(OW) + OA_W'(ox_r);
        win_first_s = (ky_r == K_ZERO) && (kx_r == K_ZERO);
        win_last_s  = (ky_r == K_LAST) && (kx_r == K_LAST);
        out_last_s  = (c_r == C_LAST) && (oy_r == Y_LAST) && (ox_r == X_LAST);
    end

    // Fetched element, sign-extended to accumulator width, and the pooled result.
    always_comb begin
        elem_s     = in_buf[in_idx_s];
        elem_ext_s = {{LOG2KK{elem_s[DATA_W-1]}}, elem_s};
        if (mode_r) begin
            // Arithmetic shift right by log2(K*K): keep the top DATA_W bits.
            result_s = acc_r[SUM_W-1:LOG2KK];
        end else begin
            result_s = acc_r[DATA_W-1:0];
        end
    end

    // Input buffer load; frozen while a pass runs, out-of-range writes dropped.
    always_ff @(posedge clk) begin
        if (!reset && wr_en && !busy && (wr_addr < IN_N_A)) begin
            in_buf[wr_addr[IA_W-1:0]] <= wr_data;
        end
    end

    // Output buffer store, one result per WRITE cycle; never cleared.
    always_ff @(posedge clk) begin
        if (!reset && (state_r == WRITE)) begin
            out_buf[out_idx_s] <= result_s;
        end
    end

    // Registered read port; addresses past the last output read as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_data <= {DATA_W{1'b0}};
        end else if (read_addr < OUT_N_A) begin
            read_data <= out_buf[read_addr[OA_W-1:0]];
        end else begin
            read_data <= {DATA_W{1'b0}};
        end
    end

    // Pass control: window walk, accumulation and output-position counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            mode_r  <= 1'b0;
            c_r     <= C_ZERO;
            oy_r    <= Y_ZERO;
            ox_r    <= X_ZERO;
            ky_r    <= K_ZERO;
            kx_r    <= K_ZERO;
            acc_r   <= {SUM_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mode_r  <= mode;
                        c_r     <= C_ZERO;
                        oy_r    <= Y_ZERO;
                        ox_r    <= X_ZERO;
                        ky_r    <= K_ZERO;
                        kx_r    <= K_ZERO;
                        done    <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= FETCH;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FETCH: begin
                    if (win_first_s) begin
                        acc_r <= elem_ext_s;
                    end else if (mode_r) begin
                        acc_r <= acc_r + elem_ext_s;
                    end else if ($signed(elem_ext_s) > $signed(acc_r)) begin
                        acc_r <= elem_ext_s;
                    end else begin
                        acc_r <= acc_r;
                    end
                    if (win_last_s) begin
                        ky_r    <= K_ZERO;
                        kx_r    <= K_ZERO;
                        state_r <= WRITE;
                    end else if (kx_r == K_LAST) begin
                        kx_r <= K_ZERO;
                        ky_r <= ky_r + K_ONE;
                    end else begin
                        kx_r <= kx_r + K_ONE;
                    end
                end
                WRITE: begin
                    if (ox_r == X_LAST) begin
                        ox_r <= X_ZERO;
                        if (oy_r == Y_LAST) begin
                            oy_r <= Y_ZERO;
                            c_r  <= c_r + C_ONE;
                        end else begin
                            oy_r <= oy_r + Y_ONE;
                        end
                    end else begin
                        ox_r <= ox_r + X_ONE;
                    end
                    state_r <= out_last_s ? FINISH : FETCH;
                end
                FINISH: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool2d_param_mode.sv
// Self-checking bench for maxpool2d_param_mode: default configuration plus a
// small K=2/STRIDE=1/5x5x2 instance, checked against a window-level model.
module tb_maxpool2d_param_mode;

    localparam int DW = 4;
    localparam int AW = 32;

    localparam int H = 8, W = 8, CH = 128, KK = 2, S = 2;
    localparam int OH = (H - KK) / S + 1;
    localparam int OW = (W - KK) / S + 1;
    localparam int OUT_N = CH * OH * OW;
    localparam int IN_N  = CH * H * W;
    localparam int LAT   = 2 + OUT_N * (KK * KK + 1);

    localparam int H2 = 5, W2 = 5, CH2 = 2, K2 = 2, S2 = 1;
    localparam int OH2 = (H2 - K2) / S2 + 1;
    localparam int OW2 = (W2 - K2) / S2 + 1;
    localparam int OUT_N2 = CH2 * OH2 * OW2;
    localparam int IN_N2  = CH2 * H2 * W2;
    localparam int LAT2   = 2 + OUT_N2 * (K2 * K2 + 1);

    logic clk, reset;
    logic start, mode, wr_en, busy, done;
    logic [AW-1:0] wr_addr, read_addr;
    logic signed [DW-1:0] wr_data, read_data;
    logic start2, mode2, wr_en2, busy2, done2;
    logic [AW-1:0] wr_addr2, read_addr2;
    logic signed [DW-1:0] wr_data2, read_data2;

    int n_checks = 0;
    int n_pass   = 0;
    int in_mem  [0:IN_N-1];
    int in_mem2 [0:IN_N2-1];
    logic signed [DW-1:0] e;

    maxpool2d_param_mode dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .read_addr(read_addr), .read_data(read_data),
        .busy(busy), .done(done)
    );

    maxpool2d_param_mode #(
        .DATA_W(DW), .IN_H(H2), .IN_W(W2), .CHANNELS(CH2), .K(K2), .STRIDE(S2), .ADDR_W(AW)
    ) dut2 (
        .clk(clk), .reset(reset), .start(start2), .mode(mode2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .read_addr(read_addr2), .read_data(read_data2),
        .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int floor_div(input int s, input int d);
        int q;
        q = s / d;
        if ((s % d != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    // Pool one output position straight from the layout formulas.
    function automatic int ref_pool(input bit alt, input int oi, input bit m);
        int h, w, k, s, oh, ow, c, oy, ox, idx, v, acc;
        h = alt ? H2 : H;   w = alt ? W2 : W;   k = alt ? K2 : KK;
        s = alt ? S2 : S;   oh = alt ? OH2 : OH; ow = alt ? OW2 : OW;
        c = oi / (oh * ow); oy = (oi / ow) % oh; ox = oi % ow;
        acc = 0;
        for (int ky = 0; ky < k; ky++) begin
            for (int kx = 0; kx < k; kx++) begin
                idx = (c * h + oy * s + ky) * w + ox * s + kx;
                v = alt ? in_mem2[idx] : in_mem[idx];
                if (ky == 0 && kx == 0) acc = v;
                else if (m) acc = acc + v;
                else if (v > acc) acc = v;
            end
        end
        return m ? floor_div(acc, k * k) : acc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_main(input int addr, input int val);
        wr_en = 1'b1; wr_addr = AW'(addr); wr_data = DW'(val);
        tick();
        wr_en = 1'b0;
        in_mem[addr] = val;
    endtask

    // Launch a pass, flip mode right after (must not matter), wait for done.
    task automatic run_pass(input bit m, output int lat);
        start = 1'b1; mode = m;
        tick();
        start = 1'b0; mode = ~m;
        lat = 1;
        while (done !== 1'b1 && lat < LAT + 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; start2 = 1'b1; read_addr = '0; read_addr2 = '0;
        repeat (3) tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        n_checks++; if (read_data !== 4'sd0) $display("FAIL reset_rdata: got %0d expected 0", read_data); else n_pass++;
        n_checks++; if (busy2 !== 1'b0 || done2 !== 1'b0) $display("FAIL reset_alt: got busy=%b done=%b expected 0 0", busy2, done2); else n_pass++;
        reset = 1'b0; start = 1'b0; start2 = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_start_ignored: got busy=%b expected 0", busy); else n_pass++;
    endtask

    task automatic test_alt_config();
        int lat;
        for (int i = 0; i < IN_N2; i++) begin
            in_mem2[i] = (i % 16) - 8;
            wr_en2 = 1'b1; wr_addr2 = AW'(i); wr_data2 = DW'(in_mem2[i]);
            tick();
        end
        wr_en2 = 1'b0;
        for (int m = 0; m < 2; m++) begin
            start2 = 1'b1; mode2 = m[0];
            tick();
            start2 = 1'b0; mode2 = ~m[0];
            lat = 1;
            while (done2 !== 1'b1 && lat < LAT2 + 50) begin tick(); lat++; end
            n_checks++; if (lat != LAT2) $display("FAIL alt_latency: got %0d expected %0d", lat, LAT2); else n_pass++;
            for (int i = 0; i <= OUT_N2; i++) begin
                read_addr2 = AW'(i);
                tick();
                e = (i < OUT_N2) ? DW'(ref_pool(1'b1, i, m[0])) : 4'sd0;
                n_checks++;
                if (read_data2 !== e) $display("FAIL alt_out[%0d] mode %0d: got %0d expected %0d", i, m, read_data2, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_max_basic();
        int lat;
        for (int i = 0; i < IN_N; i++) wr_main(i, 0);
        wr_main(0, -8); wr_main(1, 3); wr_main(8, -1); wr_main(9, 2);
        run_pass(1'b0, lat);
        n_checks++; if (lat != LAT) $display("FAIL max_latency: got %0d expected %0d", lat, LAT); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL max_busy_after: got %b expected 0", busy); else n_pass++;
        read_addr = 0; tick();
        n_checks++; if (read_data !== 4'sd3) $display("FAIL max_out0: got %0d expected 3", read_data); else n_pass++;
        read_addr = 1; tick();
        n_checks++; if (read_data !== 4'sd0) $display("FAIL max_out1: got %0d expected 0", read_data); else n_pass++;
    endtask

    task automatic test_avg_basic();
        int lat;
        wr_main(320, 1); wr_main(321, 1); wr_main(328, 1); wr_main(329, 0);
        wr_main(322, -1);
        run_pass(1'b1, lat);
        n_checks++; if (lat != LAT) $display("FAIL avg_latency: got %0d expected %0d", lat, LAT); else n_pass++;
        read_addr = 0; tick();
        n_checks++; if (read_data !== -4'sd1) $display("FAIL avg_out0: got %0d expected -1", read_data); else n_pass++;
        read_addr = 80; tick();
        n_checks++; if (read_data !== 4'sd0) $display("FAIL avg_out80: got %0d expected 0", read_data); else n_pass++;
        read_addr = 81; tick();
        n_checks++; if (read_data !== -4'sd1) $display("FAIL avg_out81: got %0d expected -1", read_data); else n_pass++;
    endtask

    task automatic test_timing_handshake();
        int k, a, v;
        bit m;
        for (int i = 0; i < 300; i++) begin
            a = $urandom_range(IN_N - 1);
            v = int'($urandom_range(15)) - 8;
            wr_main(a, v);
        end
        // Out-of-range writes must not alias onto low addresses.
        wr_en = 1'b1; wr_data = DW'((in_mem[0] == 7) ? -8 : 7);
        wr_addr = AW'(IN_N); tick();
        wr_addr = 32'hFFFF_FFFF; tick();
        wr_en = 1'b0;
        m = 1'($urandom_range(1));
        start = 1'b1; mode = m;
        tick();
        start = 1'b0; mode = ~m;
        n_checks++; if (busy !== 1'b1) $display("FAIL hs_busy_t1: got %b expected 1", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL hs_done_cleared: got %b expected 0", done); else n_pass++;
        k = 1;
        while (done !== 1'b1 && k < LAT + 50) begin
            start   = (k == 50);
            wr_en   = (k == 60);
            wr_addr = 0;
            wr_data = DW'((in_mem[0] == 7) ? -8 : 7);
            tick();
            k++;
        end
        start = 1'b0; wr_en = 1'b0;
        n_checks++; if (k != LAT) $display("FAIL hs_done_time: got %0d expected %0d", k, LAT); else n_pass++;
        for (int i = 0; i < OUT_N; i++) begin
            read_addr = AW'(i);
            tick();
            e = DW'(ref_pool(1'b0, i, m));
            n_checks++;
            if (read_data !== e) $display("FAIL hs_out[%0d]: got %0d expected %0d", i, read_data, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_pass();
        int k, lat;
        bit m;
        for (int i = 0; i < 100; i++) wr_main($urandom_range(IN_N - 1), int'($urandom_range(15)) - 8);
        m = 1'($urandom_range(1));
        start = 1'b1; mode = m;
        tick();
        start = 1'b0;
        k = 1;
        while (k < 100) begin tick(); k++; end
        reset = 1'b1; start = 1'b1; read_addr = 5;
        tick();
        reset = 1'b0; start = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_mid_done: got %b expected 0", done); else n_pass++;
        n_checks++; if (read_data !== 4'sd0) $display("FAIL rst_mid_rdata: got %0d expected 0", read_data); else n_pass++;
        tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_start_ignored: got busy=%b expected 0", busy); else n_pass++;
        run_pass(m, lat);
        n_checks++; if (lat != LAT) $display("FAIL rst_fresh_latency: got %0d expected %0d", lat, LAT); else n_pass++;
        for (int i = 0; i < OUT_N; i++) begin
            read_addr = AW'(i);
            tick();
            e = DW'(ref_pool(1'b0, i, m));
            n_checks++;
            if (read_data !== e) $display("FAIL rst_fresh_out[%0d]: got %0d expected %0d", i, read_data, e);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        int lat;
        for (int i = 0; i < IN_N; i++) wr_main(i, (i < IN_N / 2) ? -8 : 7);
        for (int m = 0; m < 2; m++) begin
            run_pass(m[0], lat);
            n_checks++; if (lat != LAT) $display("FAIL sat_latency: got %0d expected %0d", lat, LAT); else n_pass++;
            for (int i = 0; i < OUT_N; i++) begin
                read_addr = AW'(i);
                tick();
                e = DW'(ref_pool(1'b0, i, m[0]));
                n_checks++;
                if (read_data !== e) $display("FAIL sat_out[%0d] mode %0d: got %0d expected %0d", i, m, read_data, e);
                else n_pass++;
            end
        end
        read_addr = AW'(OUT_N - 1); tick();
        n_checks++; if (read_data !== 4'sd7) $display("FAIL rd_last: got %0d expected 7", read_data); else n_pass++;
        read_addr = AW'(OUT_N); tick();
        n_checks++; if (read_data !== 4'sd0) $display("FAIL rd_past_end: got %0d expected 0", read_data); else n_pass++;
        read_addr = 32'hFFFF_FFFF; tick();
        n_checks++; if (read_data !== 4'sd0) $display("FAIL rd_max_addr: got %0d expected 0", read_data); else n_pass++;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; read_addr = '0;
        start2 = 1'b0; mode2 = 1'b0; wr_en2 = 1'b0;
        wr_addr2 = '0; wr_data2 = '0; read_addr2 = '0;
        test_reset();
        test_alt_config();
        test_max_basic();
        test_avg_basic();
        test_timing_handshake();
        test_reset_mid_pass();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/maxpool2d_param_mode.md
Name: maxpool2d_param_mode

Overview:
- Parametrised 2-D pooling engine for the CNN accelerator datapath. It generalises the fixed 2x2/stride-2/128-channel max-pool stages.
- Input feature map is loaded through a write port into an internal buffer. Max or average pooling runs with configurable window, stride, dimensions and channel count.
- Results go to an internal output buffer, read through a registered read port.
- Sits between a conv/ReLU stage and the next layer or the flatten/dense stage.

Parameters:
- DATA_W, 4: signed element width (two's complement).
- IN_H, 8: input height.
- IN_W, 8: input width.
- CHANNELS, 128: channel count.
- K, 2: square pooling window size; legal values are 2 and 4 only.
- STRIDE, 2: window stride, 1..K.
- ADDR_W, 32: width of the read and write address buses.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; launches a pooling pass.
- mode  in  1  0 = max, 1 = average; sampled on accepted start.
- wr_en  in  1  input-buffer write strobe.
- wr_addr  in  ADDR_W  input-buffer address.
- wr_data  in  DATA_W  input element.
- read_addr  in  ADDR_W  output-buffer address.
- read_data  out  DATA_W  output element, registered.
- busy  out  1  high while a pass is running.
- done  out  1  level; high after pass completion until next accepted start or reset.

Behaviour:
- Derived constants:
  - OH = (IN_H-K)/STRIDE+1, floor; trailing rows not covered by a full window are dropped.
  - OW = (IN_W-K)/STRIDE+1, floor; same rule for trailing columns.
  - OUT_N = CHANNELS*OH*OW.
  - Defaults give OH = OW = 4 and OUT_N = 2048.
- Layouts (channel-major):
  - Input address = (c*IN_H + y)*IN_W + x.
  - Output address = (c*OH + oy)*OW + ox.
- Reset:
  - busy=0, done=0, read_data=0, FSM=IDLE, mode latch=0.
  - Buffer contents are not cleared.
- FSM states: IDLE, FETCH, WRITE, FINISH.
  - IDLE: start=1 and not busy -> latch mode, clear c/oy/ox/window counters, done<=0, go to FETCH. busy=1 from the next cycle.
  - FETCH: one input element per cycle, K*K cycles, row-major within the window. The accumulator is initialised with the first element.
    - Max: signed compare, keep the larger.
    - Average: signed sum of width DATA_W+log2(K*K); no overflow is possible.
  - WRITE: one cycle. Store the max, or the sum arithmetic-shifted right by log2(K*K) (floor toward -inf), at the output address. Advance ox, then oy, then c.
    - If that was the last output -> FINISH; else -> FETCH.
  - FINISH: busy<=0, done<=1, go to IDLE.
- Latency: start accepted at cycle T -> done first high at cycle T+2+OUT_N*(K*K+1). Defaults give T+10242.
- Handshake and boundary rules:
  - start while busy=1 is ignored.
  - start in IDLE while done=1 starts a new pass and clears done.
  - wr_en while busy=1 is ignored, so the input buffer is stable during a pass.
  - wr_en with wr_addr >= CHANNELS*IN_H*IN_W is ignored.
  - Reads are legal any cycle: read_data <= out_buf[read_addr] on each clk, 1-cycle latency.
  - read_addr >= OUT_N returns 0.
  - A read during a pass returns the current buffer contents, old or new.
  - reset asserted mid-pass -> IDLE next cycle, busy=0, done=0, read_data=0.
    - Already-written outputs remain in the buffer.
    - A start in the same cycle as reset is ignored.
- mode changes after an accepted start have no effect until the next start.

Test Plan:
- Max, defaults: ch0 rows 0-1, cols 0-1 = {-8,3,-1,2}; all other elements 0 -> output[0]=3, output[1]=0.
- Average, same data -> output[0] = floor(-4/4) = -1. Window {1,1,1,0} at ch5 (oy,ox)=(0,0) -> output[80]=0. Window {-1,0,0,0} -> -1.
- Saturating values: all inputs -8 -> every output -8 in both modes. All inputs 7 -> every output 7 in both modes. Verify all 2048 addresses.
- Timing and handshake:
  - start at T -> busy=1 at T+1; done=1 first at T+10242.
  - A second start pulse at T+50 is ignored (done time unchanged).
  - wr_en at T+60 with a new value does not alter that pass's results.
- Reset mid-pass: assert reset for 1 cycle at T+100 -> busy=0, done=0, read_data=0 next cycle. A fresh start then completes with correct outputs after 10242 cycles.
- Read boundaries and alternate config:
  - read_addr=2047 returns the last output one cycle later; read_addr=2048 returns 0.
  - Re-instantiate with K=2, STRIDE=1, IN_H=IN_W=5, CHANNELS=2 -> OUT_N=32, with a max-mode ramp data check.
